// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle restoring divider and sequencer for DIV/DIVU in EX.
// Produces {remainder, quotient} for the HI/LO write path after DATA_W steps.
//
// state  | meaning
// -------+-----------------------------------------------------------
// FREE   | idle, operands sampled here when a start is accepted
// BYZERO | divisor was zero, result forced to 0 on the next edge
// ON     | one restoring step per edge; sign fix-up once cnt==DATA_W
// END    | result valid, held while start_i stays high
module div_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   quo_q, quo_d;
    logic [DATA_W-1:0]   dvs_q, dvs_d;
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;

    logic                start_ok;
    logic [DATA_W-1:0]   dvd_mag;
    logic [DATA_W-1:0]   dvs_mag;
    logic [DATA_W-1:0]   shifted;
    logic [DATA_W:0]     diff;
    logic [DATA_W-1:0]   rem_fix;
    logic [DATA_W-1:0]   quo_fix;

    // Operand magnitudes, trial subtraction and final sign correction.
    always_comb begin
        start_ok = start_i && !annul_i;
        dvd_mag  = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
        dvs_mag  = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
        shifted  = {rem_q[DATA_W-2:0], quo_q[DATA_W-1]};
        diff     = {1'b0, shifted} - {1'b0, dvs_q};
        rem_fix  = neg_rem_q ? -rem_q : rem_q;
        quo_fix  = neg_quo_q ? -quo_q : quo_q;
    end

    // State register plus datapath and output flops; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FREE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    // Next-state selection; annul wins over step/finish while dividing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FREE: begin
                if (start_ok) begin
                    state_d = (opdata2_i == '0) ? S_BYZERO : S_ON;
                end
            end
            S_BYZERO: state_d = S_END;
            S_ON: begin
                if (annul_i) begin
                    state_d = S_FREE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_END;
                end
            end
            S_END: begin
                if (!start_i) begin
                    state_d = S_FREE;
                end
            end
            default: state_d = S_FREE;
        endcase
    end

    // Datapath updates and registered outputs for each state.
    always_comb begin
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;
        case (state_q)
            S_FREE: begin
                result_d = '0;
                ready_d  = 1'b0;
                if (start_ok && (opdata2_i != '0)) begin
                    cnt_d     = '0;
                    rem_d     = '0;
                    quo_d     = dvd_mag;
                    dvs_d     = dvs_mag;
                    neg_quo_d = signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                    neg_rem_d = signed_div_i && opdata1_i[DATA_W-1];
                end
            end
            S_BYZERO: begin
                result_d = '0;
                ready_d  = 1'b1;
            end
            S_ON: begin
                if (annul_i) begin
                    result_d = '0;
                    ready_d  = 1'b0;
                end else if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (diff[DATA_W]) begin
                        rem_d = shifted;
                        quo_d = {quo_q[DATA_W-2:0], 1'b0};
                    end else begin
                        rem_d = diff[DATA_W-1:0];
                        quo_d = {quo_q[DATA_W-2:0], 1'b1};
                    end
                end else begin
                    result_d = {rem_fix, quo_fix};
                    ready_d  = 1'b1;
                end
            end
            S_END: begin
                if (!start_i) begin
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end
            default: begin
                result_d = '0;
                ready_d  = 1'b0;
            end
        endcase
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
Multi-cycle iterative divider and sequencer for DIV/DIVU in the EX stage. EX drives start_i while a divide is in flight and holds the pipeline. The block runs a 32-step restoring division and returns {remainder, quotient} for the HI/LO write path. It also supports annulment when the instruction is squashed.

Parameters:
DATA_W, 32, operand width; the iteration count equals DATA_W.

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  reset, asynchronous, active-high (`RstEnable)
signed_div_i  in  1  1 = DIV (signed), 0 = DIVU
opdata1_i  in  DATA_W  dividend
opdata2_i  in  DATA_W  divisor
start_i  in  1  request from EX; held high until EX consumes the result
annul_i  in  1  abort the current division
result_o  out  2*DATA_W  {remainder (to HI), quotient (to LO)}
ready_o  out  1  result valid

Behaviour:
- Reset (async, rst=1): state=FREE, cnt=0, ready_o=0, result_o=0, internal regs=0. Outputs go low immediately, without waiting for a clock edge, including mid-division.
- States: FREE, BYZERO, ON, END. Registered single-process FSM.
- FREE:
  - start_i=1, annul_i=0, opdata2_i==0: go to BYZERO.
  - start_i=1, annul_i=0, opdata2_i!=0: go to ON. Latch operands and signed_div_i; cnt=0.
  - Operand latch, signed mode: a negative operand (bit DATA_W-1 set) is latched as its two's complement magnitude. Unsigned mode: latched as-is.
  - rem=0, quo=|dividend|.
  - Otherwise stay in FREE with ready_o=0 and result_o=0.
- BYZERO: next edge go to END with result_o=0 and ready_o=1.
- ON:
  - annul_i=1: go to FREE; ready_o=0, result_o=0; partial result discarded.
  - cnt<DATA_W: one restoring step per edge, cnt++.
    - t={rem[DATA_W-2:0],quo[DATA_W-1]} minus {0,|divisor|}, computed DATA_W+1 wide.
    - t negative: rem={rem[DATA_W-2:0],quo[DATA_W-1]}, quo={quo[DATA_W-2:0],0}.
    - else: rem=t[DATA_W-1:0], quo={quo[DATA_W-2:0],1}.
  - cnt==DATA_W: sign-correct, load result_o, ready_o=1, go to END.
    - Signed only: quotient negated if dividend and divisor signs differ.
    - Signed only: remainder negated if dividend was negative.
- END:
  - start_i=1: hold result_o and ready_o.
  - start_i=0: go to FREE; ready_o=0, result_o=0 on that edge.
- start_i changes and operand changes are ignored while in ON/BYZERO/END. Operands are sampled only in FREE.
- Latency (edges counted from the one that samples start_i in FREE):
  - Nonzero divisor: ready_o rises after edge 34 (1 load + 32 steps + 1 finish).
  - Zero divisor: ready_o rises after edge 2.
- annul_i in FREE blocks the start. annul_i in BYZERO or END has no effect.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 (wrap), remainder 0. No trap.
- No combinational path from inputs to outputs.

Test Plan:
- DIVU 100/7 (0x64/0x7), start held -> ready_o=1 after edge 34, result_o=0x00000002_0000000E; ready_o=0 at no earlier edge.
- DIV -7/2 (0xFFFFFFF9/0x00000002) -> result_o=0xFFFFFFFF_FFFFFFFD. DIV 7/-2 -> 0x00000001_FFFFFFFD.
- DIVU 5/0 -> ready_o=1 after edge 2, result_o=0.
- DIV 0x80000000/0xFFFFFFFF -> 0x00000000_80000000. DIVU 0xFFFFFFFF/1 -> 0x00000000_FFFFFFFF.
- Start DIVU 100/7, assert annul_i one cycle at edge 10 -> FREE next edge, ready_o stays 0. Then start DIVU 9/3 -> 0x00000000_00000003 after 34 edges.
- Reset and handshake:
  - rst pulse between edges mid-ON -> ready_o=0 and result_o=0 immediately; a new DIVU 100/7 afterwards completes normally.
  - In END, keep start_i high 5 cycles -> result stable. Drop start_i -> ready_o=0 and result_o=0 on the next edge.
